// File: rtl/spi_controller.sv
// rtl/spi_controller.sv - write-only mode-0 SPI initiator sending {1, addr, data} frames
module spi_controller #(
    parameter int HALF_PERIOD = 4,
    parameter int TRAIL_CLKS  = 1,
    parameter int CS_GAP      = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [6:0] addr,
    input  logic [7:0] data,
    output logic       busy,
    output logic       done,
    output logic       SCLK,
    output logic       nCS,
    output logic       COPI
);

    localparam int MAX_LEN = (HALF_PERIOD > CS_GAP) ? HALF_PERIOD : CS_GAP;
    localparam int DIV_W   = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam logic [DIV_W-1:0] HP_LAST  = DIV_W'(HALF_PERIOD - 1);
    localparam logic [DIV_W-1:0] GAP_LAST = DIV_W'(CS_GAP - 1);
    localparam logic [4:0]       PULSES   = 5'(16 + TRAIL_CLKS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEAD,
        S_SCK_HI,
        S_SCK_LO,
        S_GAP
    } state_t;

    state_t           state_q, state_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [4:0]       cnt_q, cnt_d;
    logic [15:0]      shift_q, shift_d;
    logic             sclk_q, sclk_d;
    logic             ncs_q, ncs_d;
    logic             copi_q, copi_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    always_comb begin
        state_d = state_q;
        div_d   = div_q + DIV_W'(1);
        cnt_d   = cnt_q;
        shift_d = shift_q;
        done_d  = 1'b0;

        case (state_q)
            S_IDLE: begin
                div_d = '0;
                if (start) begin
                    state_d = S_LEAD;
                    shift_d = {1'b1, addr, data};
                    cnt_d   = '0;
                end
            end
            S_LEAD: begin
                if (div_q == HP_LAST) state_d = S_SCK_HI;
            end
            S_SCK_HI: begin
                // Shift on the falling SCLK edge; zeros fill in behind so trailing pulses carry COPI=0.
                if (div_q == HP_LAST) begin
                    state_d = S_SCK_LO;
                    shift_d = {shift_q[14:0], 1'b0};
                    cnt_d   = cnt_q + 5'd1;
                end
            end
            S_SCK_LO: begin
                if (div_q == HP_LAST) state_d = (cnt_q < PULSES) ? S_SCK_HI : S_GAP;
            end
            S_GAP: begin
                if (div_q == GAP_LAST) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (state_d != state_q) div_d = '0;

        // Outputs are decoded from the next state so they register together with it.
        sclk_d = (state_d == S_SCK_HI);
        ncs_d  = !((state_d == S_LEAD) || (state_d == S_SCK_HI) || (state_d == S_SCK_LO));
        copi_d = ncs_d ? 1'b0 : shift_d[15];
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            div_q   <= '0;
            cnt_q   <= '0;
            shift_q <= '0;
            sclk_q  <= 1'b0;
            ncs_q   <= 1'b1;
            copi_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
            sclk_q  <= sclk_d;
            ncs_q   <= ncs_d;
            copi_q  <= copi_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign SCLK = sclk_q;
    assign nCS  = ncs_q;
    assign COPI = copi_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_spi_controller.sv
// tb/tb_spi_controller.sv - directed vector bench for spi_controller (default and fast parameter sets)
module tb_spi_controller;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [1:0] rst_v, start_v, busy_v, done_v, sclk_v, ncs_v, copi_v;
    logic [6:0] addr_v [2];
    logic [7:0] data_v [2];
    logic       idle_en [2];

    spi_controller u_dut0 (
        .clk(clk), .rst(rst_v[0]), .start(start_v[0]), .addr(addr_v[0]), .data(data_v[0]),
        .busy(busy_v[0]), .done(done_v[0]), .SCLK(sclk_v[0]), .nCS(ncs_v[0]), .COPI(copi_v[0])
    );

    spi_controller #(.HALF_PERIOD(3), .TRAIL_CLKS(0), .CS_GAP(1)) u_dut1 (
        .clk(clk), .rst(rst_v[1]), .start(start_v[1]), .addr(addr_v[1]), .data(data_v[1]),
        .busy(busy_v[1]), .done(done_v[1]), .SCLK(sclk_v[1]), .nCS(ncs_v[1]), .COPI(copi_v[1])
    );

    function automatic int hp(input int g);
        return (g == 0) ? 4 : 3;
    endfunction

    // Line monitor: samples both DUTs on the falling clk edge.
    int          rises [2], stable [2], setup_bad [2], hold_bad [2], trail_bad [2];
    int          low_run [2], high_run [2], last_low [2], last_high [2], frames [2];
    int          last_rises [2], last_setup [2], last_hold [2], last_trail [2];
    int          acc_cyc [2], done_lat [2], done_cnt [2], done_long [2], idle_cnt [2];
    logic [15:0] word [2], last_word [2];
    logic        prev_sclk [2], prev_copi [2], prev_ncs [2], prev_busy [2], prev_done [2];

    always @(negedge clk) begin
        for (int g = 0; g < 2; g++) begin
            int eff;
            eff = (copi_v[g] == prev_copi[g]) ? stable[g] + 1 : 0;
            stable[g]    <= eff;
            prev_sclk[g] <= sclk_v[g];
            prev_copi[g] <= copi_v[g];
            prev_ncs[g]  <= ncs_v[g];
            prev_busy[g] <= busy_v[g];
            prev_done[g] <= done_v[g];
            if (!ncs_v[g] && prev_ncs[g]) begin
                rises[g] <= 0; word[g] <= '0; setup_bad[g] <= 0; hold_bad[g] <= 0; trail_bad[g] <= 0;
                low_run[g] <= 1; last_high[g] <= high_run[g];
            end else if (!ncs_v[g]) begin
                low_run[g] <= low_run[g] + 1;
                if (sclk_v[g] && !prev_sclk[g]) begin
                    rises[g] <= rises[g] + 1;
                    if (rises[g] < 16) word[g] <= {word[g][14:0], copi_v[g]};
                    else if (copi_v[g]) trail_bad[g] <= trail_bad[g] + 1;
                    if (eff < hp(g)) setup_bad[g] <= setup_bad[g] + 1;
                end
                if (sclk_v[g] && prev_sclk[g] && copi_v[g] != prev_copi[g]) hold_bad[g] <= hold_bad[g] + 1;
            end else if (ncs_v[g] && !prev_ncs[g]) begin
                last_low[g] <= low_run[g]; last_word[g] <= word[g]; last_rises[g] <= rises[g];
                last_setup[g] <= setup_bad[g]; last_hold[g] <= hold_bad[g]; last_trail[g] <= trail_bad[g];
                frames[g] <= frames[g] + 1; high_run[g] <= 1;
            end else begin
                high_run[g] <= high_run[g] + 1;
            end
            acc_cyc[g] <= (busy_v[g] && !prev_busy[g]) ? 0 : acc_cyc[g] + 1;
            if (done_v[g]) begin
                done_cnt[g] <= done_cnt[g] + 1;
                done_lat[g] <= acc_cyc[g] + 1;
            end
            if (done_v[g] && prev_done[g]) done_long[g] <= done_long[g] + 1;
            if (!idle_en[g]) idle_cnt[g] <= 0;
            else if (!busy_v[g] && !done_v[g]) idle_cnt[g] <= idle_cnt[g] + 1;
        end
    end

    typedef struct {
        logic [6:0]  a;
        logic [7:0]  d;
        logic [15:0] exp;
    } vec_t;
    vec_t v [6];

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h (%0d) expected 0x%0h (%0d)", name, act, act, exp, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // which: 0 = frames, 1 = done pulses, 2 = live SCLK rises
    task automatic wait_for(input string name, input int which, input int g, input int target, input int budget);
        int n;
        int cur;
        n = 0;
        cur = 0;
        while (n <= budget) begin
            case (which)
                0: cur = frames[g];
                1: cur = done_cnt[g];
                default: cur = rises[g];
            endcase
            if (cur >= target) break;
            tick();
            n++;
        end
        if (cur < target) begin
            n_chk++;
            n_err++;
            $display("FAIL timeout_%s: got %0d expected %0d", name, cur, target);
        end
    endtask

    task automatic do_frame(input int g, input int i, input int exp_rises, input int exp_low, input int exp_lat);
        int f0;
        int d0;
        f0 = frames[g];
        d0 = done_cnt[g];
        addr_v[g] = v[i].a;
        data_v[g] = v[i].d;
        start_v[g] = 1'b1;
        tick();
        start_v[g] = 1'b0;
        wait_for("frame", 0, g, f0 + 1, 400);
        chk("word", int'(last_word[g]), int'(v[i].exp));
        chk("rises", last_rises[g], exp_rises);
        chk("ncs_low", last_low[g], exp_low);
        chk("copi_setup", last_setup[g], 0);
        chk("copi_hold", last_hold[g], 0);
        chk("trail_copi", last_trail[g], 0);
        wait_for("done", 1, g, d0 + 1, 50);
        chk("done_latency", done_lat[g], exp_lat);
    endtask

    initial begin
        int f0;
        int d0;
        v[0] = '{7'h04, 8'h80, 16'h8480};
        v[1] = '{7'h00, 8'hFF, 16'h80FF};
        v[2] = '{7'h01, 8'h0F, 16'h810F};
        v[3] = '{7'h02, 8'hA5, 16'h82A5};
        v[4] = '{7'h03, 8'h3C, 16'h833C};
        v[5] = '{7'h5A, 8'hC3, 16'hDAC3};

        rst_v = 2'b11;
        start_v = 2'b00;
        for (int g = 0; g < 2; g++) begin
            addr_v[g] = '0;
            data_v[g] = '0;
            idle_en[g] = 1'b0;
        end
        repeat (3) tick();
        chk("reset_outputs_dut0", {sclk_v[0], ncs_v[0], copi_v[0], busy_v[0], done_v[0]}, 5'b01000);
        chk("reset_outputs_dut1", {sclk_v[1], ncs_v[1], copi_v[1], busy_v[1], done_v[1]}, 5'b01000);
        rst_v = 2'b00;
        repeat (2) tick();

        // Single write with default parameters.
        do_frame(0, 0, 17, 140, 144);
        chk("done_width", done_long[0], 0);

        // start held high across three frames.
        f0 = frames[0];
        d0 = done_cnt[0];
        addr_v[0] = v[1].a;
        data_v[0] = v[1].d;
        start_v[0] = 1'b1;
        tick();
        idle_en[0] = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            wait_for("b2b_frame", 0, 0, f0 + k, 400);
            chk("b2b_word", int'(last_word[0]), int'(v[k].exp));
            chk("b2b_rises", last_rises[0], 17);
            if (k > 1) chk("b2b_ncs_high", last_high[0], 5);
            if (k < 3) begin
                addr_v[0] = v[k + 1].a;
                data_v[0] = v[k + 1].d;
            end else begin
                start_v[0] = 1'b0;
            end
        end
        wait_for("b2b_done", 1, 0, d0 + 3, 50);
        chk("b2b_idle_cycles", idle_cnt[0], 0);
        idle_en[0] = 1'b0;
        repeat (20) tick();
        chk("b2b_frame_count", frames[0] - f0, 3);

        // start while busy is ignored and addr/data changes do not leak into the frame.
        f0 = frames[0];
        d0 = done_cnt[0];
        addr_v[0] = v[0].a;
        data_v[0] = v[0].d;
        start_v[0] = 1'b1;
        tick();
        start_v[0] = 1'b0;
        repeat (19) tick();
        addr_v[0] = 7'h7F;
        data_v[0] = 8'h00;
        start_v[0] = 1'b1;
        tick();
        start_v[0] = 1'b0;
        wait_for("ign_frame", 0, 0, f0 + 1, 400);
        chk("ign_word", int'(last_word[0]), int'(v[0].exp));
        repeat (200) tick();
        chk("ign_done_count", done_cnt[0] - d0, 1);
        chk("ign_frame_count", frames[0] - f0, 1);

        // Asynchronous reset after seven SCLK rises.
        d0 = done_cnt[0];
        addr_v[0] = v[1].a;
        data_v[0] = v[1].d;
        start_v[0] = 1'b1;
        tick();
        start_v[0] = 1'b0;
        wait_for("rst_rises", 2, 0, 7, 200);
        chk("rst_pre_busy", {busy_v[0], sclk_v[0]}, 2'b11);
        rst_v[0] = 1'b1;
        #1;
        chk("rst_async_outputs", {sclk_v[0], ncs_v[0], copi_v[0], busy_v[0], done_v[0]}, 5'b01000);
        #1;
        rst_v[0] = 1'b0;
        repeat (200) tick();
        chk("rst_no_done", done_cnt[0] - d0, 0);
        do_frame(0, 4, 17, 140, 144);

        // Fast parameter set: HALF_PERIOD=3, TRAIL_CLKS=0, CS_GAP=1.
        do_frame(1, 5, 16, 99, 100);
        chk("fast_done_width", done_long[1], 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/spi_controller.md
# spi_controller

Write-only SPI initiator (mode 0) that drives 16-bit register-write frames onto SCLK/nCS/COPI toward the chip's SPI register peripheral. It sits on the bench/controller side and turns a single-cycle start request with a 7-bit address and 8-bit data into a complete, correctly paced frame. SCLK is derived from the system clock by a programmable divider. The divider and phase lengths are sized so a receiver using a 2-flop synchronizer on the same clock domain detects every SCLK edge.

## Interface

Parameters:
- HALF_PERIOD, 4: clk cycles per SCLK phase, high or low; legal range ≥3.
- TRAIL_CLKS, 1: extra SCLK pulses after bit 0 with COPI=0, used as commit pulses; legal range 0..3.
- CS_GAP, 4: clk cycles nCS is held high after a frame before done; legal range ≥1.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- rst  in  1  reset; asynchronous, active-high.
- start  in  1  request; sampled only when busy=0.
- addr  in  7  register address, latched on accept.
- data  in  8  write data, latched on accept.
- busy  out  1  frame in progress, including the CS gap.
- done  out  1  one-cycle pulse when the frame and gap complete.
- SCLK  out  1  serial clock; idles low.
- nCS  out  1  chip select, active-low.
- COPI  out  1  serial data, MSB first.

## Operation

- Frame word: {1'b1, addr[6:0], data[7:0]}. Bit 15 (write flag) is sent first; data[0] is sent last.
- States:
  - IDLE: SCLK=0, nCS=1, COPI=0, busy=0.
  - LEAD: nCS=0, SCLK=0, COPI=bit15; lasts HALF_PERIOD cycles.
  - SCK_HI: SCLK=1; lasts HALF_PERIOD cycles.
  - SCK_LO: SCLK=0; lasts HALF_PERIOD cycles.
  - GAP: nCS=1, SCLK=0, COPI=0; lasts CS_GAP cycles.
- Transitions:
  - IDLE→LEAD: on the edge sampling start=1. The same edge latches addr and data into the shift register and sets busy=1, nCS=0, COPI=bit15.
  - LEAD→SCK_HI.
  - SCK_HI→SCK_LO: COPI shifts to the next bit on this transition (falling SCLK). After the 16th high phase COPI=0 for all trailing pulses.
  - SCK_LO→SCK_HI: while pulses sent < 16+TRAIL_CLKS.
  - SCK_LO→GAP: after the last pulse.
  - GAP→IDLE: busy→0 and done→1 for exactly one cycle.
- COPI is stable for a full HALF_PERIOD before each rising SCLK and through the whole high phase.
- Counters:
  - Pulse counter is 5 bits, 0..16+TRAIL_CLKS, with no wrap.
  - Divider counter is clog2(max(HALF_PERIOD, CS_GAP)) bits and reloads on each state change.
- start while busy=1 is ignored and not queued. addr/data changes after accept have no effect on the frame in flight.
- Reset (asynchronous, any state): SCLK=0, nCS=1, COPI=0, busy=0, done=0, state=IDLE, counters and shift register cleared. A partial frame is abandoned with no done and no retry.

## Timing

- Accept edge → nCS low: 0 cycles (same edge).
- nCS low duration: HALF_PERIOD·(1 + 2·(16+TRAIL_CLKS)) cycles. Defaults give 140.
- First SCLK rise: HALF_PERIOD cycles after nCS falls.
- nCS high→done: CS_GAP cycles. done coincides with busy falling.
- Back-to-back: start held high is next accepted on the edge after done. Minimum nCS high time between frames is CS_GAP+1 cycles.
- Total accept→done: 140+4 = 144 cycles with defaults.
- Outputs are registered; no combinational path from inputs to outputs.

## Test plan

- Single write, defaults, addr=0x04, data=0x80:
  - Sampling COPI at SCLK rises gives 0x8480, then one extra rise with COPI=0.
  - 17 rises total; nCS low exactly 140 cycles; done one cycle, 144 cycles after accept.
- start held high for three frames (0x00/0xFF, 0x01/0x0F, 0x02/0xA5): three correct frames, nCS high ≥5 cycles between them, three done pulses, busy low only in done cycles.
- start pulsed at cycle 20 of a frame with different addr/data: ignored; frame in flight still carries original word; exactly one done.
- rst asserted mid-frame after 7 SCLK rises: nCS=1, SCLK=0, COPI=0, busy=0 immediately (asynchronous, before next clk edge); no done. Next frame 0x03/0x3C is correct.
- HALF_PERIOD=3, TRAIL_CLKS=0, CS_GAP=1: 16 rises, nCS low 99 cycles, COPI stable 3 cycles before every rise, done 100 cycles after accept.
